// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for calculator_seq_engine.
//   OP_* constants   bit positions inside the one-hot operation code
//   calc_state_e     FSM states of the top-level sequencer
//   is_one_hot()     true when exactly one bit of a 4-bit code is set
// Optional feature macro used by the design files: CALC_DIVIDE_EN.
package calc_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } calc_state_e;

  // x & (x-1) clears the lowest set bit; a one-hot code leaves nothing behind.
  function automatic logic is_one_hot(input logic [3:0] code);
    return (code != 4'b0000) && ((code & (code - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// calc_iter_unit: one-bit-per-cycle multiply / divide datapath.
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   load_i         capture operands and mode, clear the accumulator
//   step_i         perform one iteration
//   mode_i         0 = shift-add multiply, 1 = restoring divide
//   a_i, b_i       operand A (multiplicand / dividend), B (multiplier / divisor)
//   result_o       {hi, lo}: product, or {remainder, quotient}
// With CALC_DIVIDE_EN undefined the restoring-subtract step is not built.
module calc_iter_unit #(
  parameter int WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               mode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] result_o
);

  // hi/lo form one double-width shift register; m holds the fixed operand.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   mul_sum;
`ifdef CALC_DIVIDE_EN
  logic             mode_q, mode_d;
  logic [WIDTH:0]   div_shift;
`endif

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    // Multiply: add multiplicand when the current multiplier LSB is set,
    // then shift {carry, hi, lo} right so the next multiplier bit surfaces.
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
`ifdef CALC_DIVIDE_EN
    mode_d    = mode_q;
    // Divide: bring the next dividend bit into the partial remainder.
    div_shift = {hi_q, lo_q[WIDTH-1]};
`endif
    if (load_i) begin
      hi_d = '0;
`ifdef CALC_DIVIDE_EN
      mode_d = mode_i;
`endif
      if (mode_i) begin
        lo_d = a_i;
        m_d  = b_i;
      end else begin
        lo_d = b_i;
        m_d  = a_i;
      end
    end else if (step_i) begin
`ifdef CALC_DIVIDE_EN
      if (mode_q) begin
        if (div_shift >= {1'b0, m_q}) begin
          hi_d = WIDTH'(div_shift - {1'b0, m_q});
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else
`endif
      begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
`ifdef CALC_DIVIDE_EN
      mode_q <= 1'b0;
`endif
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q  <= m_d;
`ifdef CALC_DIVIDE_EN
      mode_q <= mode_d;
`endif
    end
  end

  assign result_o = {hi_q, lo_q};

endmodule

// File: rtl/calculator_seq_engine.sv
// calculator_seq_engine: multi-cycle add / subtract / multiply / divide.
//   IN_clk, IN_reset_n       clock, asynchronous active-low reset
//   IN_num1, IN_num2         unsigned operands A and B
//   IN_operation_code        one-hot {div, mul, sub, add}
//   IN_start                 request, sampled only while idle
//   OUT_busy, OUT_done       handshake: busy until done, done is a 1-cycle pulse
//   OUT_answer               2*WIDTH-bit result, held until the next accept
//   OUT_is_negative          subtract result was negative
//   OUT_error                invalid code or divide by zero
// Macro CALC_DIVIDE_EN enables the divider; otherwise divide is an invalid code.
module calculator_seq_engine
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               IN_clk,
  input  logic               IN_reset_n,
  input  logic [WIDTH-1:0]   IN_num1,
  input  logic [WIDTH-1:0]   IN_num2,
  input  logic [3:0]         IN_operation_code,
  input  logic               IN_start,
  output logic               OUT_busy,
  output logic               OUT_done,
  output logic [2*WIDTH-1:0] OUT_answer,
  output logic               OUT_is_negative,
  output logic               OUT_error
);

  localparam int CNT_W = $clog2(WIDTH);

  calc_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] answer_q, answer_d;
  logic               neg_q, neg_d;
  logic               err_q, err_d;
  // Staged result for single-cycle operations, published in DONE.
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               res_neg_q, res_neg_d;
  logic               res_err_q, res_err_d;
  logic               use_iter_q, use_iter_d;

  logic               iter_load, iter_step;
  logic [2*WIDTH-1:0] iter_result;
  logic [WIDTH:0]     add_sum;

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk_i    (IN_clk),
    .rst_ni   (IN_reset_n),
    .load_i   (iter_load),
    .step_i   (iter_step),
    .mode_i   (IN_operation_code[OP_DIV]),
    .a_i      (IN_num1),
    .b_i      (IN_num2),
    .result_o (iter_result)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    answer_d   = answer_q;
    neg_d      = neg_q;
    err_d      = err_q;
    res_d      = res_q;
    res_neg_d  = res_neg_q;
    res_err_d  = res_err_q;
    use_iter_d = use_iter_q;
    iter_load  = 1'b0;
    iter_step  = 1'b0;
    add_sum    = {1'b0, IN_num1} + {1'b0, IN_num2};

    case (state_q)
      IDLE: begin
        if (IN_start) begin
          busy_d     = 1'b1;
          answer_d   = '0;
          neg_d      = 1'b0;
          err_d      = 1'b0;
          res_d      = '0;
          res_neg_d  = 1'b0;
          res_err_d  = 1'b0;
          use_iter_d = 1'b0;
          state_d    = DONE;
          if (!is_one_hot(IN_operation_code)) begin
            res_err_d = 1'b1;
          end else if (IN_operation_code[OP_ADD]) begin
            res_d = {{(WIDTH-1){1'b0}}, add_sum};
          end else if (IN_operation_code[OP_SUB]) begin
            if (IN_num1 < IN_num2) begin
              res_d     = {{WIDTH{1'b0}}, IN_num2 - IN_num1};
              res_neg_d = 1'b1;
            end else begin
              res_d = {{WIDTH{1'b0}}, IN_num1 - IN_num2};
            end
          end else if (IN_operation_code[OP_MUL]) begin
            iter_load  = 1'b1;
            use_iter_d = 1'b1;
            cnt_d      = '0;
            state_d    = CALC;
          end else begin
`ifdef CALC_DIVIDE_EN
            if (IN_num2 == '0) begin
              res_err_d = 1'b1;
            end else begin
              iter_load  = 1'b1;
              use_iter_d = 1'b1;
              cnt_d      = '0;
              state_d    = CALC;
            end
`else
            res_err_d = 1'b1;
`endif
          end
        end
      end
      CALC: begin
        iter_step = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        answer_d = use_iter_q ? iter_result : res_q;
        neg_d    = res_neg_q;
        err_d    = res_err_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge IN_clk or negedge IN_reset_n) begin
    if (!IN_reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      answer_q   <= '0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
      res_q      <= '0;
      res_neg_q  <= 1'b0;
      res_err_q  <= 1'b0;
      use_iter_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      answer_q   <= answer_d;
      neg_q      <= neg_d;
      err_q      <= err_d;
      res_q      <= res_d;
      res_neg_q  <= res_neg_d;
      res_err_q  <= res_err_d;
      use_iter_q <= use_iter_d;
    end
  end

  assign OUT_busy        = busy_q;
  assign OUT_done        = done_q;
  assign OUT_answer      = answer_q;
  assign OUT_is_negative = neg_q;
  assign OUT_error       = err_q;

endmodule

// File: tb/tb_calculator_seq_engine.sv
// tb_calculator_seq_engine: directed self-checking bench, WIDTH=16.
module tb_calculator_seq_engine;

  localparam int W = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [W-1:0]    num1 = '0;
  logic [W-1:0]    num2 = '0;
  logic [3:0]      code = '0;
  logic            start = 1'b0;
  logic            busy, done, neg, err;
  logic [2*W-1:0]  answer;

  int tests = 0;
  int fails = 0;

  calculator_seq_engine #(.WIDTH(W)) dut (
    .IN_clk            (clk),
    .IN_reset_n        (reset_n),
    .IN_num1           (num1),
    .IN_num2           (num2),
    .IN_operation_code (code),
    .IN_start          (start),
    .OUT_busy          (busy),
    .OUT_done          (done),
    .OUT_answer        (answer),
    .OUT_is_negative   (neg),
    .OUT_error         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check latency, result, flags, and hold behaviour.
  // poke=1 drives a competing start with other operands while busy.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] c, input int exp_lat, input logic [2*W-1:0] exp_ans,
                        input logic exp_neg, input logic exp_err, input bit poke);
    int lat;
    bit seen;
    @(negedge clk);
    num1 = a; num2 = b; code = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    num1 = ~a; num2 = ~b;   // operand changes after acceptance must not matter
    check({tag, "_busy_at_accept"}, 64'(busy), 64'd1);
    check({tag, "_answer_cleared"}, 64'(answer), 64'd0);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
      if (poke && lat == 4) begin num1 = 16'h0003; num2 = 16'h0003; code = 4'b0001; start = 1'b1; end
      if (poke && lat == 5) begin start = 1'b0; code = c; end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_answer"}, 64'(answer), 64'(exp_ans));
    check({tag, "_neg"}, 64'(neg), 64'(exp_neg));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse_ends"}, 64'(done), 64'd0);
    check({tag, "_answer_held"}, 64'(answer), 64'(exp_ans));
    $display("[TB] %s a=0x%0h b=0x%0h code=%b latency=%0d answer=0x%0h neg=%0d err=%0d",
             tag, a, b, c, lat, answer, neg, err);
  endtask

  initial begin
    int done_seen;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_answer", 64'(answer), 64'd0);
    check("reset_neg", 64'(neg), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op("add_carry", 16'hFFFF, 16'h0001, 4'b0001, 1, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    run_op("sub_neg",   16'd5,    16'd9,    4'b0010, 1, 32'd4,         1'b1, 1'b0, 1'b0);
    run_op("sub_equal", 16'd9,    16'd9,    4'b0010, 1, 32'd0,         1'b0, 1'b0, 1'b0);
    run_op("sub_pos",   16'd1000, 16'd1,    4'b0010, 1, 32'd999,       1'b0, 1'b0, 1'b0);
    run_op("mul_max",   16'hFFFF, 16'hFFFF, 4'b0100, 17, 32'hFFFE_0001, 1'b0, 1'b0, 1'b1);
    run_op("mul_small", 16'd123,  16'd45,   4'b0100, 17, 32'd5535,     1'b0, 1'b0, 1'b0);
`ifdef CALC_DIVIDE_EN
    run_op("div_100_7", 16'd100,  16'd7,    4'b1000, 17, 32'h0002_000E, 1'b0, 1'b0, 1'b0);
    run_op("div_by_0",  16'd42,   16'd0,    4'b1000, 1,  32'd0,         1'b0, 1'b1, 1'b0);
`else
    run_op("div_off",   16'd100,  16'd7,    4'b1000, 1,  32'd0,         1'b0, 1'b1, 1'b0);
`endif
    run_op("code_0110", 16'd5,    16'd3,    4'b0110, 1, 32'd0,         1'b0, 1'b1, 1'b0);
    run_op("code_0000", 16'd5,    16'd3,    4'b0000, 1, 32'd0,         1'b0, 1'b1, 1'b0);

    // Abort a multiply with reset at its 8th cycle.
    @(negedge clk);
    num1 = 16'hFFFF; num2 = 16'hFFFF; code = 4'b0100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_answer", 64'(answer), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    reset_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    $display("[TB] abort multiply at cycle 8, done pulses seen=%0d", done_seen);

    run_op("add_after_reset", 16'd3, 16'd4, 4'b0001, 1, 32'd7, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calculator_seq_engine.md
# calculator_seq_engine

Parametrised, multi-cycle successor to the calculator's combinational calculation stage. It accepts two unsigned WIDTH-bit operands and a one-hot operation code, and performs add, subtract, iterative shift-add multiply or restoring divide. It reports a registered 2·WIDTH-bit result with a sign flag and an error flag through a start/busy/done handshake. It sits between the keypad/operand registers and the display driver.

## Interface
- WIDTH, 16, operand width in bits, ≥4. The result is 2·WIDTH bits.
- IN_clk  in  1  rising-edge clock
- IN_reset_n  in  1  asynchronous active-low reset
- IN_num1  in  WIDTH  unsigned operand A (dividend)
- IN_num2  in  WIDTH  unsigned operand B (divisor)
- IN_operation_code  in  4  one-hot: [3] divide, [2] multiply, [1] subtract, [0] add
- IN_start  in  1  request; sampled only when OUT_busy=0
- OUT_busy  out  1  high from the accepting edge until the edge that raises OUT_done
- OUT_done  out  1  one-cycle pulse when the result is valid
- OUT_answer  out  2·WIDTH  result magnitude; held until the next accepted start
- OUT_is_negative  out  1  subtract result was negative
- OUT_error  out  1  invalid code or divide-by-zero; held with OUT_answer

## Operation
- States:
  - IDLE: waits for a start.
  - CALC: multiply/divide iterations; iteration counter runs 0..WIDTH-1.
  - DONE: one cycle; pulses OUT_done and returns to IDLE.
- IDLE accepting start:
  - Operands and code are latched.
  - OUT_answer, OUT_is_negative and OUT_error are cleared.
  - Add/subtract/invalid: result computed and stored, go to DONE.
  - Multiply/divide: go to CALC.
- Add: OUT_answer = zero-extended A+B; carry lands in bit WIDTH.
- Subtract: OUT_answer = |A−B| zero-extended; OUT_is_negative = (A<B). A=B gives 0 and is_negative=0.
- Multiply: unsigned shift-add, one partial product per cycle, LSB of B first. Full 2·WIDTH-bit product.
- Divide: restoring, one quotient bit per cycle, MSB first. OUT_answer = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
- Divide with B=0: skips CALC and goes straight to DONE, with answer 0 and error 1.
- Invalid code (zero, or more than one bit set): answer 0, error 1, latency as add.
- OUT_is_negative is 0 for every operation other than subtract.
- IN_start while busy is ignored. Operand changes after acceptance have no effect.

## Timing
- Reset values (asynchronous, immediate): state IDLE; counter 0; OUT_busy, OUT_done, OUT_answer, OUT_is_negative and OUT_error all 0.
- Latency L is measured from the accepting edge E to the edge that raises OUT_done (high for the cycle after edge E+L):
  - add, subtract, invalid, divide-by-zero: L=1.
  - multiply, divide: L=WIDTH+1.
- OUT_answer and the flags update on the same edge that raises OUT_done.
- OUT_busy falls on that same edge. A new start may be sampled on the next edge, giving one idle cycle minimum between operations.
- Reset asserted mid-CALC aborts the operation: no done pulse and the answer is cleared.
- Counter wrap: exiting CALC happens when the counter reaches WIDTH-1. The counter never wraps.

## Configuration
- CALC_DIVIDE_EN:
  - Defined: divide supported as above.
  - Undefined: divider datapath not built; code bit [3] is treated as an invalid code (answer 0, error 1, L=1).

## Structure
- Package calc_pkg holds:
  - op-bit index constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3;
  - the state enumeration (IDLE, CALC, DONE);
  - a function that tests whether a code is one-hot.
- One sub-module, calc_iter_unit: holds the per-cycle shift-add / restoring-subtract step and its accumulator registers. Its mode input selects multiply or divide. The top level owns the FSM, handshake and add/subtract path.

## Test plan (WIDTH=16)
- Add 0xFFFF + 0x0001 → answer 0x0001_0000, neg 0, error 0; done 1 cycle after accept.
- Subtract 5 − 9 → answer 4, neg 1; then 9 − 9 → answer 0, neg 0.
- Multiply 0xFFFF × 0xFFFF → 0xFFFE_0001, done exactly 17 cycles after accept. Pulse IN_start with new operands mid-run → ignored, result unchanged.
- Divide 100 / 7 → answer 0x0002_000E, done at 17 cycles. Divide 42 / 0 → answer 0, error 1, done at 1 cycle. Without CALC_DIVIDE_EN, 100 / 7 → error 1.
- Code 4'b0110 and code 4'b0000 → answer 0, error 1, done at 1 cycle.
- Assert IN_reset_n low at cycle 8 of a multiply → all outputs 0 immediately, no done pulse. After release, add 3 + 4 → 7.
